// File: rtl/bus_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
package bus_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Never returns less than 1 so derived vectors stay non-empty.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational picker: first set request at or above i_start,
// wrapping back to index 0.
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    localparam int MSEL_W = clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [MSEL_W-1:0]      i_start,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [MSEL_W-1:0]      o_idx,
    output logic                   o_valid
);

    logic [MSEL_W-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_j = MSEL_W'(wrap_add(int'(i_start), i, NUM_MASTERS));
            if (!o_valid && i_req[w_j]) begin
                o_valid      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_nm.sv
// N-master bus arbiter: fixed or round-robin priority, SPLIT parking
// with resume on split_grant and timeout release.
module bus_arbiter_nm
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int RR_MODE       = 1,
    parameter int SPLIT_TIMEOUT = 255,
    localparam int MSEL_W       = clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    input  logic                   sready,
    input  logic                   ssplit,
    input  logic                   split_grant,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic                   split_timeout
);

    localparam int CNT_W = clog2(SPLIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPLIT_TIMEOUT - 1);
    localparam logic [MSEL_W-1:0] LAST_M   = MSEL_W'(NUM_MASTERS - 1);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_bgrant;
    logic [NUM_MASTERS-1:0] r_msplit;
    logic [MSEL_W-1:0]      r_owner;
    logic [MSEL_W-1:0]      r_split_owner;
    logic [MSEL_W-1:0]      r_rr_ptr;
    logic                   r_busy;
    logic                   r_split_pending;
    logic                   r_split_timeout;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_parked;
    logic                   w_expire;
    logic                   w_win_vld;
    logic [NUM_MASTERS-1:0] w_elig;
    logic [NUM_MASTERS-1:0] w_win_oh;
    logic [MSEL_W-1:0]      w_start;
    logic [MSEL_W-1:0]      w_win_idx;
    logic [MSEL_W-1:0]      w_next_ptr;

    assign w_parked   = |r_msplit;
    assign w_elig     = breq & ~r_msplit;
    assign w_start    = (RR_MODE == MODE_RR) ? r_rr_ptr : '0;
    assign w_next_ptr = (r_owner == LAST_M) ? '0 : r_owner + 1'b1;

    // A resume request arriving with the expiry cycle beats the timeout.
    assign w_expire = (SPLIT_TIMEOUT > 0) && w_parked && !r_split_pending &&
                      !split_grant && (r_cnt == CNT_LAST);

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_grant (w_win_oh),
        .o_idx   (w_win_idx),
        .o_valid (w_win_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= ST_IDLE;
            r_bgrant        <= '0;
            r_msplit        <= '0;
            r_owner         <= '0;
            r_split_owner   <= '0;
            r_rr_ptr        <= '0;
            r_busy          <= 1'b0;
            r_split_pending <= 1'b0;
            r_split_timeout <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_split_timeout <= 1'b0;
            if (w_parked) begin
                if (split_grant) r_split_pending <= 1'b1;
                if (w_expire) begin
                    r_msplit        <= '0;
                    r_split_timeout <= 1'b1;
                    r_cnt           <= '0;
                end else if (!r_split_pending && r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (r_split_pending) begin
                        r_state         <= ST_GRANT;
                        r_bgrant        <= r_msplit;
                        r_owner         <= r_split_owner;
                        r_busy          <= 1'b1;
                        r_msplit        <= '0;
                        r_split_pending <= 1'b0;
                        r_cnt           <= '0;
                    end else if (sready && w_win_vld) begin
                        r_state  <= ST_GRANT;
                        r_bgrant <= w_win_oh;
                        r_owner  <= w_win_idx;
                        r_busy   <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (ssplit && !w_parked) begin
                        r_state       <= ST_IDLE;
                        r_bgrant      <= '0;
                        r_busy        <= 1'b0;
                        r_msplit      <= r_bgrant;
                        r_split_owner <= r_owner;
                        r_cnt         <= '0;
                        r_rr_ptr      <= w_next_ptr;
                    end else if (!breq[r_owner]) begin
                        r_state  <= ST_IDLE;
                        r_bgrant <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
            endcase
        end
    end

    assign bgrant        = r_bgrant;
    assign msel          = r_owner;
    assign bus_busy      = r_busy;
    assign msplit        = r_msplit;
    assign split_timeout = r_split_timeout;

endmodule
